// File: rtl/saci_pkg.sv
// saci_pkg: shared types and helpers for the SACI command scheduler.
// Frame layout is {start, rw, cmd, addr, wdata}, 53 bits.
package saci_pkg;

  localparam int   SACI_DWIDTH    = 53;
  localparam logic SACI_START_BIT = 1'b1;
  localparam int   SACI_CW        = 13;

  typedef struct packed {
    logic        rw;
    logic [6:0]  cmd;
    logic [11:0] addr;
    logic [31:0] wdata;
  } saci_req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } sched_state_e;

  function automatic logic [SACI_DWIDTH-1:0] saci_frame(
    input saci_req_t r
  );
    return {SACI_START_BIT, r.rw, r.cmd, r.addr, r.wdata};
  endfunction

endpackage

// File: rtl/saci_rr_arbiter.sv
// saci_rr_arbiter: combinational round-robin pick of the first
// request at or after the pointer; pointer state is held by the caller.
module saci_rr_arbiter #(
  parameter int  NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  int w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = int'(i_ptr) + i;
      if (w_k >= NREQ) w_k = w_k - NREQ;
      if (i_en && !o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = PW'(w_k);
      end
    end
  end

endmodule

// File: rtl/saci_cmd_scheduler.sv
// saci_cmd_scheduler: shares one saci_master between NREQ requesters,
// framing commands, tracking busy and returning read data or timeouts.
module saci_cmd_scheduler
  import saci_pkg::*;
#(
  parameter int  NREQ    = 4,
  parameter int  NCHIP   = 3,
  parameter int  TIMEOUT = 4096,
  localparam int CHIPW   = (NCHIP > 1) ? $clog2(NCHIP) : 1,
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  saci_req_t [NREQ-1:0]        req_cmd_i,
  input  logic [NREQ-1:0][CHIPW-1:0]  req_chip_i,
  output logic [NREQ-1:0]             resp_valid_o,
  output logic [31:0]                 resp_rdata_o,
  output logic                        resp_err_o,
  output logic                        saci_start_o,
  output logic [NCHIP-1:0]            saci_slave_mask_o,
  output logic [SACI_DWIDTH-1:0]      saci_data_o,
  input  logic                        saci_busy_i,
  input  logic [31:0]                 saci_rdata_i
);

  localparam logic [CHIPW:0]     NCHIP_LIM = (CHIPW+1)'(NCHIP);
  localparam logic [SACI_CW-1:0] TMO_LAST  = SACI_CW'(TIMEOUT - 1);

  sched_state_e        r_state;
  sched_state_e        w_next;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_gnt;
  saci_req_t           r_req;
  logic [CHIPW-1:0]    r_chip;
  logic [SACI_CW-1:0]  r_cnt;
  logic [SACI_CW-1:0]  w_cnt_inc;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic                w_en;
  logic [NREQ-1:0]     w_gnt_oh;
  logic [PW-1:0]       w_gnt_idx;
  logic                w_any;
  logic [CHIPW-1:0]    w_sel_chip;
  logic                w_bad;
  logic [PW-1:0]       w_ptr_nxt;
  logic                w_tmo;
  logic                w_active;

  assign w_en = rst_n && (r_state == S_IDLE) && !saci_busy_i;

  saci_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  assign w_sel_chip = req_chip_i[w_gnt_idx];
  assign w_bad      = {1'b0, w_sel_chip} >= NCHIP_LIM;
  assign w_ptr_nxt  = (w_gnt_idx == PW'(NREQ - 1)) ?
                      '0 : w_gnt_idx + PW'(1);
  // counts cycles since the current wait phase began, saturating
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + SACI_CW'(1);
  assign w_tmo      = r_cnt >= TMO_LAST;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_next = w_bad ? S_RESP : S_LAUNCH;
      end
      S_LAUNCH: w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (saci_busy_i)  w_next = S_WAIT_DONE;
        else if (w_tmo)   w_next = S_RESP;
      end
      S_WAIT_DONE: begin
        if (!saci_busy_i) w_next = S_RESP;
        else if (w_tmo)   w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_req   <= '0;
      r_chip  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt_idx;
            r_req   <= req_cmd_i[w_gnt_idx];
            r_chip  <= w_sel_chip;
            r_ptr   <= w_ptr_nxt;
            r_err   <= w_bad;
            r_rdata <= '0;
          end
        end
        S_LAUNCH: r_cnt <= SACI_CW'(1);
        S_WAIT_BUSY: begin
          if (saci_busy_i) begin
            r_cnt <= SACI_CW'(1);
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_tmo) r_err <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!saci_busy_i) begin
            r_rdata <= r_req.rw ? saci_rdata_i : '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_tmo) r_err <= 1'b1;
          end
        end
        S_RESP: r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign w_active = (r_state == S_LAUNCH) ||
                    (r_state == S_WAIT_BUSY) ||
                    (r_state == S_WAIT_DONE);

  always_comb begin
    req_ready_o       = w_gnt_oh;
    saci_start_o      = (r_state == S_LAUNCH);
    saci_slave_mask_o = '1;
    saci_data_o       = '0;
    resp_valid_o      = '0;
    resp_rdata_o      = '0;
    resp_err_o        = 1'b0;
    if (w_active) begin
      saci_slave_mask_o = ~(NCHIP'(1) << r_chip);
      saci_data_o       = saci_frame(r_req);
    end
    if (r_state == S_RESP) begin
      resp_valid_o = NREQ'(1) << r_gnt;
      resp_rdata_o = r_rdata;
      resp_err_o   = r_err;
    end
  end

endmodule

// File: tb/tb_saci_cmd_scheduler.sv
// tb_saci_cmd_scheduler: directed stimulus with a transaction-level
// expectation model and a simple saci_master responder.
module tb_saci_cmd_scheduler;
  import saci_pkg::*;

  localparam int NREQ    = 4;
  localparam int NCHIP   = 3;
  localparam int TIMEOUT = 4096;

  typedef struct {
    bit          never;
    int          d;
    int          l;
    logic [31:0] rd;
  } prof_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  saci_req_t [3:0]      req_cmd;
  logic [3:0][1:0]      req_chip;
  logic [3:0]           resp_valid;
  logic [31:0]          resp_rdata;
  logic                 resp_err;
  logic                 saci_start;
  logic [2:0]           saci_mask;
  logic [52:0]          saci_data;
  logic                 saci_busy;
  logic [31:0]          saci_rdata;

  always #5 clk = ~clk;

  saci_cmd_scheduler #(
    .NREQ    (NREQ),
    .NCHIP   (NCHIP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_cmd_i         (req_cmd),
    .req_chip_i        (req_chip),
    .resp_valid_o      (resp_valid),
    .resp_rdata_o      (resp_rdata),
    .resp_err_o        (resp_err),
    .saci_start_o      (saci_start),
    .saci_slave_mask_o (saci_mask),
    .saci_data_o       (saci_data),
    .saci_busy_i       (saci_busy),
    .saci_rdata_i      (saci_rdata)
  );

  int pass = 0;
  int total = 0;
  int cyc = 0;

  prof_t mq[$];
  prof_t sq[$];

  // master responder timeline
  bit          ms_act = 0;
  int          ms_rise, ms_fall;
  logic [31:0] ms_rd = '0;

  // expectation model
  int          m_ptr = 0;
  bit          m_act = 0;
  int          m_g, m_start, m_resp;
  int          m_free = 0;
  bit          m_bad, m_err;
  logic [1:0]  m_chip;
  logic [52:0] m_frame;
  logic [31:0] m_rd;

  // observation log
  logic [3:0]  acc_seen = '0;
  int          glog[$];
  int          start_cnt = 0, resp_cnt = 0, viol = 0;
  bit          seen_busy = 0, prev_busy = 0;
  int          last_grant_cyc, last_start_cyc, last_resp_cyc, last_fall_cyc;
  logic [52:0] last_sdata;
  logic [2:0]  last_smask;
  logic [3:0]  last_rv;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add_prof(bit nv, int d, int l, logic [31:0] rd);
    prof_t p;
    p.never = nv; p.d = d; p.l = l; p.rd = rd;
    mq.push_back(p);
    sq.push_back(p);
  endtask

  task automatic observe();
    logic [3:0]  e_rdy, e_rv;
    logic        e_st, e_err;
    logic [2:0]  e_mask;
    logic [52:0] e_data;
    logic [31:0] e_rd;
    bit          win;
    int          j;
    prof_t       p;
    acc_seen = req_ready;
    if (!rst_n) begin
      m_ptr  = 0;
      m_act  = 0;
      m_free = cyc + 1;
      return;
    end
    for (int k = 0; k < 4; k++)
      if (req_ready[k]) begin glog.push_back(k); last_grant_cyc = cyc; end
    if (saci_busy) seen_busy = 1;
    if (prev_busy && !saci_busy) last_fall_cyc = cyc;
    prev_busy = saci_busy;
    if (saci_start) begin
      if (start_cnt > 0 && !seen_busy) viol++;
      seen_busy = 0;
      start_cnt++;
      last_start_cyc = cyc;
      last_sdata = saci_data;
      last_smask = saci_mask;
      if (sq.size() > 0) p = sq.pop_front();
      else begin p.never = 0; p.d = 0; p.l = 1; p.rd = '0; end
      if (!p.never) begin
        ms_act = 1; ms_rise = cyc + 1 + p.d; ms_fall = ms_rise + p.l;
        ms_rd = p.rd;
      end
    end
    if (resp_valid != 0) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      last_rv = resp_valid; last_rd = resp_rdata; last_err = resp_err;
    end
    // model: who is granted, and when each output phase happens
    if (m_act && cyc > m_resp) m_act = 0;
    e_rdy = '0;
    if (!m_act && cyc >= m_free && !saci_busy && req_valid != 0) begin
      m_g = 0;
      for (int k = 3; k >= 0; k--) begin
        j = (m_ptr + k) % 4;
        if (req_valid[j]) m_g = j;
      end
      m_act = 1;
      e_rdy = 4'b0001 << m_g;
      m_ptr = (m_g + 1) % 4;
      m_chip = req_chip[m_g];
      m_bad = (int'(m_chip) >= NCHIP);
      m_frame = {1'b1, req_cmd[m_g].rw, req_cmd[m_g].cmd,
                 req_cmd[m_g].addr, req_cmd[m_g].wdata};
      m_start = cyc + 1;
      if (m_bad) begin
        m_resp = cyc + 1; m_err = 1; m_rd = '0;
      end else begin
        if (mq.size() > 0) p = mq.pop_front();
        else begin p.never = 0; p.d = 0; p.l = 1; p.rd = '0; end
        if (p.never) begin
          m_resp = m_start + TIMEOUT; m_err = 1; m_rd = '0;
        end else begin
          m_resp = m_start + p.d + p.l + 2; m_err = 0;
          m_rd = req_cmd[m_g].rw ? p.rd : '0;
        end
      end
      m_free = m_resp + 1;
    end
    win    = m_act && !m_bad && cyc >= m_start && cyc < m_resp;
    e_st   = m_act && !m_bad && cyc == m_start;
    e_mask = win ? ~(3'b001 << m_chip) : 3'b111;
    e_data = win ? m_frame : '0;
    e_rv   = (m_act && cyc == m_resp) ? (4'b0001 << m_g) : 4'b0000;
    e_rd   = (m_act && cyc == m_resp) ? m_rd : '0;
    e_err  = m_act && cyc == m_resp && m_err;
    chk("ready", req_ready, e_rdy);
    chk("start", saci_start, e_st);
    chk("mask", saci_mask, e_mask);
    chk("data", saci_data, e_data);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_rdata", resp_rdata, e_rd);
    chk("resp_err", resp_err, e_err);
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    req_valid = req_valid & ~acc_seen;
    saci_busy = ms_act && cyc >= ms_rise && cyc < ms_fall;
    if (ms_act && cyc >= ms_fall) ms_act = 0;
    saci_rdata = ms_rd;
  endtask

  task automatic wait_resp(string nm, int max);
    int r0, n;
    r0 = resp_cnt; n = 0;
    while (resp_cnt == r0 && n < max) begin tick(); n++; end
    if (resp_cnt == r0) begin
      total++;
      $display("FAIL %s: no response within %0d cycles", nm, max);
    end
  endtask

  task automatic wait_grants(string nm, int cnt, int max);
    int n;
    n = 0;
    while (glog.size() < cnt && n < max) begin tick(); n++; end
    if (glog.size() < cnt) begin
      total++;
      $display("FAIL %s: %0d grants, wanted %0d", nm, glog.size(), cnt);
    end
  endtask

  initial begin
    int n0, s0, r0, v0, n;
    bit re;
    rst_n = 0; req_valid = '0; req_cmd = '0; req_chip = '0;
    saci_busy = 0; saci_rdata = '0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("rst_mask", saci_mask, 3'b111);
    chk("rst_data", saci_data, 53'h0);
    chk("rst_start", saci_start, 1'b0);
    chk("rst_rv", resp_valid, 4'b0000);

    // single write to chip 0
    add_prof(0, 1, 3, 32'h0);
    req_cmd[0] = '{rw:1'b0, cmd:7'h01, addr:12'h010, wdata:32'hDEADBEEF};
    req_chip[0] = 2'd0; req_valid[0] = 1'b1;
    s0 = start_cnt;
    wait_resp("wr_resp", 40);
    chk("wr_frame", last_sdata, 53'h10_1010_DEADBEEF);
    chk("wr_mask", last_smask, 3'b110);
    chk("wr_rv", last_rv, 4'b0001);
    chk("wr_err", last_err, 1'b0);
    chk("wr_starts", start_cnt - s0, 1);

    // read from chip 2 via requester 2
    add_prof(0, 2, 4, 32'hCAFE0001);
    req_cmd[2] = '{rw:1'b1, cmd:7'h02, addr:12'h123, wdata:32'h0};
    req_chip[2] = 2'd2; req_valid[2] = 1'b1;
    wait_resp("rd_resp", 40);
    chk("rd_frame", last_sdata, 53'h18_2123_00000000);
    chk("rd_mask", last_smask, 3'b011);
    chk("rd_rdata", last_rd, 32'hCAFE0001);
    chk("rd_rv", last_rv, 4'b0100);
    chk("rd_acc2start", last_start_cyc - last_grant_cyc, 1);
    chk("rd_fall2resp", last_resp_cyc - last_fall_cyc, 1);

    // contention from reset
    rst_n = 0; tick(); rst_n = 1; tick();
    n0 = glog.size(); v0 = viol; r0 = resp_cnt;
    repeat (5) add_prof(0, 0, 2, 32'h0);
    for (int k = 0; k < 4; k++) begin
      req_cmd[k] = '{rw:1'b0, cmd:7'(k + 8), addr:12'(k * 16), wdata:32'(k)};
      req_chip[k] = 2'(k % 3);
    end
    req_valid = 4'b1111;
    re = 0; n = 0;
    while (resp_cnt < r0 + 5 && n < 200) begin
      tick(); n++;
      if (!re && glog.size() == n0 + 1) begin req_valid[0] = 1'b1; re = 1; end
    end
    if (resp_cnt < r0 + 5) begin
      total++;
      $display("FAIL cont_resp: %0d responses, wanted 5", resp_cnt - r0);
    end
    for (int k = 0; k < 5; k++)
      if (glog.size() > n0 + k)
        chk($sformatf("cont_g%0d", k), glog[n0 + k], (k == 4) ? 0 : k);
    chk("cont_busy_gap", viol - v0, 0);

    // timeout: master never raises busy
    add_prof(1, 0, 0, 32'h0);
    req_cmd[1] = '{rw:1'b0, cmd:7'h05, addr:12'h055, wdata:32'h5};
    req_chip[1] = 2'd1; req_valid[1] = 1'b1;
    wait_resp("to_resp", TIMEOUT + 50);
    chk("to_delta", last_resp_cyc - last_start_cyc, TIMEOUT);
    chk("to_err", last_err, 1'b1);
    chk("to_rdata", last_rd, 32'h0);
    chk("to_rv", last_rv, 4'b0010);
    add_prof(0, 0, 1, 32'h12345678);
    req_cmd[3] = '{rw:1'b1, cmd:7'h06, addr:12'h0AA, wdata:32'h0};
    req_chip[3] = 2'd0; req_valid[3] = 1'b1;
    wait_resp("nx_resp", 40);
    chk("nx_rdata", last_rd, 32'h12345678);
    chk("nx_rv", last_rv, 4'b1000);
    chk("nx_err", last_err, 1'b0);

    // bad chip index
    s0 = start_cnt;
    req_cmd[0] = '{rw:1'b1, cmd:7'h07, addr:12'h001, wdata:32'h0};
    req_chip[0] = 2'd3; req_valid[0] = 1'b1;
    wait_resp("bad_resp", 20);
    chk("bad_starts", start_cnt - s0, 0);
    chk("bad_lat", last_resp_cyc - last_grant_cyc, 1);
    chk("bad_err", last_err, 1'b1);
    chk("bad_rdata", last_rd, 32'h0);
    chk("bad_rv", last_rv, 4'b0001);

    // reset during WAIT_DONE
    add_prof(0, 0, 10, 32'h0);
    req_cmd[2] = '{rw:1'b1, cmd:7'h09, addr:12'h200, wdata:32'h0};
    req_chip[2] = 2'd1; req_valid[2] = 1'b1;
    s0 = start_cnt; n = 0;
    while (start_cnt == s0 && n < 20) begin tick(); n++; end
    if (start_cnt == s0) begin
      total++;
      $display("FAIL mid_start: no start within 20 cycles");
    end
    repeat (4) tick();
    r0 = resp_cnt;
    rst_n = 0; tick(); rst_n = 1;
    chk("mid_mask", saci_mask, 3'b111);
    chk("mid_data", saci_data, 53'h0);
    chk("mid_start", saci_start, 1'b0);
    chk("mid_rv", resp_valid, 4'b0000);
    chk("mid_ready", req_ready, 4'b0000);
    repeat (12) tick();
    chk("mid_noresp", resp_cnt - r0, 0);
    add_prof(0, 0, 1, 32'h0);
    add_prof(0, 0, 1, 32'h0);
    req_cmd[3] = '{rw:1'b0, cmd:7'h0A, addr:12'h300, wdata:32'hA};
    req_chip[2] = 2'd0; req_chip[3] = 2'd1;
    n0 = glog.size();
    req_valid = 4'b1100;
    wait_grants("mid_grants", n0 + 2, 60);
    if (glog.size() >= n0 + 2) begin
      chk("mid_ptr0", glog[n0], 2);
      chk("mid_ptr1", glog[n0 + 1], 3);
    end
    repeat (10) tick();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
